// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer for a 5-stage RISC-V pipeline, placed
//               beside the ID stage. It detects load-use hazards and handles
//               ID-resolved redirects (taken branch, JAL/JALR). It also runs
//               a start/done handshake with a multi-cycle MUL/DIV unit in EX,
//               which is guarded by a watchdog.
//               Outputs are Mealy: they depend on the FSM state and on the
//               current inputs.
// Ports       : clk, rst (synchronous, active-high)
//               MemRead_ex, rdAddr_ex       - load in EX and its destination
//               rs1Addr_id, rs2Addr_id      - sources of the ID instruction
//               Branch, Jump                - redirect resolved in ID
//               MdOp_id, MdDone_ex          - MUL/DIV issue / completion
//               IFWrite, IDWrite            - PC and IF/ID enables
//               IFFlush, IDFlush            - IF/ID clear, ID/EX bubble
//               EXHold                      - freeze ID/EX and EX/MEM
//               MdStart                     - one-cycle start pulse
//               MdTimeout                   - sticky watchdog-abort flag
//               StallCycles, FlushCount     - statistics counters
// Config      : `define STALL_STATS_EN to build the saturating statistics
//               counters; otherwise StallCycles/FlushCount are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int REG_AW        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_ex,
  input  logic [REG_AW-1:0] rdAddr_ex,
  input  logic [REG_AW-1:0] rs1Addr_id,
  input  logic [REG_AW-1:0] rs2Addr_id,
  input  logic              Branch,
  input  logic              Jump,
  input  logic              MdOp_id,
  input  logic              MdDone_ex,
  output logic              IFWrite,
  output logic              IDWrite,
  output logic              IFFlush,
  output logic              IDFlush,
  output logic              EXHold,
  output logic              MdStart,
  output logic              MdTimeout,
  output logic [31:0]       StallCycles,
  output logic [31:0]       FlushCount
);

  localparam int                c_WD_W    = $clog2(MD_MAX_CYCLES) + 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(MD_MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LD_STALL = 2'd1,
    S_MD_WAIT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_WD_W-1:0] r_wd;
  logic              r_timeout;
  logic              w_hazard;
  logic              w_redirect;
  logic              w_wd_clr;
  logic              w_wd_inc;
  logic              w_timeout_set;

  // The x0 destination never creates a dependency.
  assign w_hazard   = MemRead_ex && (rdAddr_ex != '0) &&
                      ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));
  assign w_redirect = Branch || Jump;
  assign MdTimeout  = r_timeout;

  always_comb begin
    IFWrite       = 1'b1;
    IDWrite       = 1'b1;
    IFFlush       = 1'b0;
    IDFlush       = 1'b0;
    EXHold        = 1'b0;
    MdStart       = 1'b0;
    w_state_nxt   = S_IDLE;
    w_wd_clr      = 1'b0;
    w_wd_inc      = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      S_MD_WAIT: begin
        if (MdDone_ex) begin
          w_state_nxt = S_IDLE;
        end else if (r_wd == c_WD_LAST) begin
          // Abort: release the pipeline and flag the timeout.
          w_timeout_set = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          // ID is frozen, so a redirect there is not acted on yet.
          IFWrite     = 1'b0;
          IDWrite     = 1'b0;
          EXHold      = 1'b1;
          w_wd_inc    = 1'b1;
          w_state_nxt = S_MD_WAIT;
        end
      end
      default: begin
        // IDLE and LD_STALL share rules; LD_STALL masks the hazard check
        // because the bubble is already in EX.
        if (w_hazard && (r_state == S_IDLE)) begin
          // Redirect ignored here: the branch compared stale rs data.
          IFWrite     = 1'b0;
          IDWrite     = 1'b0;
          IDFlush     = 1'b1;
          w_state_nxt = S_LD_STALL;
        end else if (w_redirect) begin
          IFFlush     = 1'b1;
        end else if (MdOp_id) begin
          MdStart     = 1'b1;
          w_wd_clr    = 1'b1;
          w_state_nxt = S_MD_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wd_clr) begin
        r_wd <= '0;
      end else if (w_wd_inc && (r_wd != c_WD_LAST)) begin
        r_wd <= r_wd + 1'b1;
      end
      if (w_timeout_set) begin
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!IFWrite && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (IFFlush && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign StallCycles = r_stall_cycles;
  assign FlushCount  = r_flush_count;
`else
  assign StallCycles = 32'h0;
  assign FlushCount  = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. It runs directed
//               scenarios followed by randomized cycles, and compares every
//               cycle against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MDMAX = 8;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemRead_ex;
  logic [AW-1:0] rdAddr_ex;
  logic [AW-1:0] rs1Addr_id;
  logic [AW-1:0] rs2Addr_id;
  logic          Branch;
  logic          Jump;
  logic          MdOp_id;
  logic          MdDone_ex;
  logic          IFWrite;
  logic          IDWrite;
  logic          IFFlush;
  logic          IDFlush;
  logic          EXHold;
  logic          MdStart;
  logic          MdTimeout;
  logic [31:0]   StallCycles;
  logic [31:0]   FlushCount;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  bit          m_bubble;   // a load bubble was inserted last cycle
  bit          m_md;       // waiting for a MUL/DIV result
  int          m_el;       // wait cycles already spent without done
  bit          m_to;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_MAX_CYCLES(MDMAX), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .Branch(Branch),
    .Jump(Jump), .MdOp_id(MdOp_id), .MdDone_ex(MdDone_ex),
    .IFWrite(IFWrite), .IDWrite(IDWrite), .IFFlush(IFFlush),
    .IDFlush(IDFlush), .EXHold(EXHold), .MdStart(MdStart),
    .MdTimeout(MdTimeout), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit mr, input logic [AW-1:0] rd,
                      input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                      input bit br, input bit j, input bit md, input bit dn);
    bit e_ifw, e_idw, e_iff, e_idf, e_exh, e_ms;
    bit n_bubble, n_md, n_to;
    int n_el;
    bit hz;
    @(negedge clk);
    rst = r; MemRead_ex = mr; rdAddr_ex = rd; rs1Addr_id = s1; rs2Addr_id = s2;
    Branch = br; Jump = j; MdOp_id = md; MdDone_ex = dn;
    #1;
    e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0; e_exh = 0; e_ms = 0;
    n_bubble = 0; n_md = m_md; n_el = m_el; n_to = m_to;
    if (m_md) begin
      if (dn) n_md = 0;
      else if (m_el >= MDMAX - 1) begin n_md = 0; n_to = 1; end
      else begin e_ifw = 0; e_idw = 0; e_exh = 1; n_el = m_el + 1; end
    end else begin
      hz = !m_bubble && mr && (rd != 0) && (rd == s1 || rd == s2);
      if (hz) begin e_ifw = 0; e_idw = 0; e_idf = 1; n_bubble = 1; end
      else if (br || j) e_iff = 1;
      else if (md) begin e_ms = 1; n_md = 1; n_el = 0; end
    end
    check("ctl", {26'd0, IFWrite, IDWrite, IFFlush, IDFlush, EXHold, MdStart},
                 {26'd0, e_ifw, e_idw, e_iff, e_idf, e_exh, e_ms});
    check("MdTimeout", {31'd0, MdTimeout}, {31'd0, m_to});
`ifdef STALL_STATS_EN
    check("StallCycles", StallCycles, m_sc);
    check("FlushCount", FlushCount, m_fc);
`else
    check("StallCycles", StallCycles, 32'h0);
    check("FlushCount", FlushCount, 32'h0);
`endif
    if (r) begin
      m_bubble = 0; m_md = 0; m_el = 0; m_to = 0; m_sc = 0; m_fc = 0;
    end else begin
      m_bubble = n_bubble; m_md = n_md; m_el = n_el; m_to = n_to;
      if (!e_ifw && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (e_iff && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_bubble = 0; m_md = 0; m_el = 0; m_to = 0; m_sc = 0; m_fc = 0;
    rst = 1; MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    Branch = 0; Jump = 0; MdOp_id = 0; MdDone_ex = 0;
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // T1: load-use on rs1, one bubble, then masked on the repeat
    step(0, 1, 5, 5, 0, 0, 0, 0, 0);
    step(0, 1, 5, 5, 0, 0, 0, 0, 0);
    idle();
    // T2: x0 destination is exempt
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // T3: hazard with branch, branch held next cycle
    step(0, 1, 7, 0, 7, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    // Redirect wins over MUL/DIV issue
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle();
    // T4: MUL/DIV done at cycle +5
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle();
    // MdDone outside MD_WAIT is ignored
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // T5: watchdog abort
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MDMAX) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // T6: reset during MD_WAIT, late done ignored
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
           AW'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
